// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter that lets NREQ requesters share
// the write port of one synchronous FIFO. A grant lasts until the owner sends
// a beat flagged last, or until MAX_BURST beats have been written, whichever
// comes first. One IDLE arbitration cycle separates consecutive bursts.
module fifo_wr_arbiter #(
    parameter int WIDTH     = 16,
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*WIDTH-1:0]    req_data,
    input  logic [NREQ-1:0]          req_last,
    output logic [NREQ-1:0]          req_ready,
    output logic [WIDTH-1:0]         fifo_data_in,
    output logic                     fifo_write_en,
    input  logic                     fifo_full,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     busy
);

    localparam int               IDW         = $clog2(NREQ);
    localparam logic [7:0]       MAX_BURST_C = 8'(MAX_BURST);
    localparam logic [IDW-1:0]   LAST_IDX    = IDW'(NREQ - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  owner_q, owner_d;
    logic [IDW-1:0]  last_grant_q, last_grant_d;
    logic [7:0]      beat_cnt_q, beat_cnt_d;

    logic [WIDTH-1:0] data_arr [NREQ];
    logic             owner_valid;
    logic             owner_last;
    logic             beat_xfer;
    logic [7:0]       beat_cnt_inc;
    logic             burst_done;

    // First requester with valid set, scanning circularly from last+1, so the
    // previous owner is considered last and the scan wraps past NREQ-1 to 0.
    function automatic logic [IDW-1:0] rr_pick(
        input logic [NREQ-1:0] valid,
        input logic [IDW-1:0]  last
    );
        logic [IDW-1:0] pick;
        logic [IDW-1:0] idx;
        logic           found;
        pick  = last;
        found = 1'b0;
        for (int off = 1; off <= NREQ; off++) begin
            idx = IDW'((int'(last) + off) % NREQ);
            if (!found && valid[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Split the flat data bus into one word per requester for clean muxing.
    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign data_arr[g] = req_data[g*WIDTH +: WIDTH];
    end

    // Only the owner's valid and last are looked at during a burst; the
    // other requesters are ignored until the next IDLE arbitration cycle.
    assign owner_valid  = req_valid[owner_q];
    assign owner_last   = req_last[owner_q];
    assign beat_xfer    = (state_q == BURST) && owner_valid && !fifo_full;
    assign beat_cnt_inc = beat_cnt_q + 8'd1;
    assign burst_done   = owner_last || (beat_cnt_inc == MAX_BURST_C);

    // State register.
    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge values, regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Owner, round-robin pointer and beat counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q      <= '0;
            last_grant_q <= LAST_IDX;
            beat_cnt_q   <= '0;
        end else begin
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    // Next-state logic: arbitrate in IDLE, count beats and terminate in BURST.
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    owner_d    = rr_pick(req_valid, last_grant_q);
                    beat_cnt_d = '0;
                    state_d    = BURST;
                end
            end
            BURST: begin
                // A stalled or silent owner keeps the grant; the counter
                // advances only on beats that actually reach the FIFO.
                if (beat_xfer) begin
                    beat_cnt_d = beat_cnt_inc;
                    if (burst_done) begin
                        state_d      = IDLE;
                        last_grant_d = owner_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic: handshake and FIFO write are combinational off the owner,
    // and forced quiet while reset is held, even if a burst was in flight.
    always_comb begin
        req_ready     = '0;
        fifo_write_en = 1'b0;
        busy          = 1'b0;
        fifo_data_in  = data_arr[owner_q];
        grant_id      = last_grant_q;
        if (state_q == BURST) begin
            grant_id = owner_q;
            if (!rst) begin
                busy               = 1'b1;
                req_ready[owner_q] = !fifo_full;
                fifo_write_en      = owner_valid && !fifo_full;
            end
        end
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
Parameters:
REQ-001 SHALL have parameter WIDTH, default 16, giving the data width in bits.
REQ-002 SHALL have parameter NREQ, default 4, giving the number of requesters (2..8).
REQ-003 SHALL have parameter MAX_BURST, default 8, giving the maximum beats per grant (1..255).

Ports:
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port req_valid, input, NREQ bits: per-requester data valid.
REQ-007 SHALL have port req_data, input, NREQ*WIDTH bits: requester i's data in bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port req_last, input, NREQ bits: the current beat is the last of the burst.
REQ-009 SHALL have port req_ready, output, NREQ bits: per-requester accept.
REQ-010 SHALL have port fifo_data_in, output, WIDTH bits: drives the shared synchronous FIFO data_in.
REQ-011 SHALL have port fifo_write_en, output, 1 bit: drives the FIFO write_en.
REQ-012 SHALL have port fifo_full, input, 1 bit: the FIFO full flag.
REQ-013 SHALL have port grant_id, output, clog2(NREQ) bits: the current owner index.
REQ-014 SHALL have port busy, output, 1 bit: high while in BURST.

Function
REQ-015 SHALL implement a two-state FSM, IDLE and BURST, with a registered state, owner, last_grant and 8-bit beat counter.
REQ-016 In IDLE with any req_valid set, SHALL select the first set bit scanning circularly from last_grant+1, load owner, clear the beat counter, and enter BURST on the next edge.
REQ-017 In IDLE, SHALL hold all req_ready=0 and fifo_write_en=0; no data moves during the arbitration cycle.
REQ-018 In BURST, SHALL drive req_ready[owner] = !fifo_full combinationally, and all other req_ready bits to 0.
REQ-019 In BURST, SHALL drive fifo_write_en = req_valid[owner] && !fifo_full, and fifo_data_in = req_data slice of owner, combinationally.
REQ-020 A beat SHALL transfer when req_valid[owner] && req_ready[owner]; each transfer increments the beat counter.
REQ-021 SHALL leave BURST for IDLE, updating last_grant=owner, on a transfer with req_last[owner]=1 or on the transfer that makes the beat count equal MAX_BURST, whichever occurs first.
REQ-022 In BURST, if the owner deasserts req_valid, SHALL keep the grant, with no write, until termination per REQ-021.
REQ-023 While fifo_full=1, SHALL perform no write and not advance the counter; it SHALL resume on the first cycle fifo_full=0 with no data loss or duplication.
REQ-024 Minimum grant-to-grant gap SHALL be one IDLE cycle, so there is a one-cycle bubble between bursts.
REQ-025 Round-robin SHALL wrap: after owner NREQ-1 the scan starts at 0.
REQ-026 Requests arriving during BURST SHALL be arbitrated only in the next IDLE cycle.
REQ-027 grant_id SHALL equal owner in BURST and hold last_grant in IDLE.
REQ-028 busy SHALL be 1 exactly when the state is BURST.
REQ-029 Only the owner's req_valid and req_last SHALL be observed in BURST.

Reset
REQ-030 On rst=1 at a clock edge, SHALL set state=IDLE, beat counter=0, owner=0, last_grant=NREQ-1 (so requester 0 has first priority), and grant_id=NREQ-1.
REQ-031 While rst=1, SHALL hold fifo_write_en=0, req_ready=0 and busy=0.
REQ-032 Reset mid-burst SHALL abort the burst; the next grant after rst drops follows REQ-030 priority.

Verification
REQ-033 Reset, then req_valid=4'b0110 held -> grant 1 (busy=1 one cycle later), 3 beats with last on the 3rd, one IDLE cycle, then grant 2.
REQ-034 All four valid, each sending 2-beat bursts with last on beat 2 -> grant order 0,1,2,3,0; fifo_write_en high 2 of every 3 cycles; FIFO contents match scoreboard order.
REQ-035 Requester 0 streams 20 beats with req_last=0 and MAX_BURST=8 -> beats 8 and 16 end the grant; if requester 2 is valid, it is granted after each 8-beat chunk.
REQ-036 fifo_full asserted for 5 cycles mid-burst -> fifo_write_en=0 and req_ready=0 for those cycles, beat count frozen, no lost or duplicated words.
REQ-037 rst pulsed during the 3rd beat of requester 3's burst -> state IDLE; after release with req_valid=4'b1001, requester 0 is granted first.
